// File: rtl/lab1_imul_pkg.sv
// Shared types and widths for the iterative multiplier control/datapath pair.
package lab1_imul_pkg;

  localparam int unsigned nbits       = 32;
  localparam int unsigned shamt_nbits = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lab1_imul_int_mul_alt_ctrl_if.sv
// Handshake and datapath-control bundle between the multiplier controller and datapath.
interface lab1_imul_int_mul_alt_ctrl_if
  import lab1_imul_pkg::*;
#(
  parameter int unsigned c_nbits       = nbits,
  parameter int unsigned c_shamt_nbits = shamt_nbits
) ();

  logic                     req_val;
  logic                     req_rdy;
  logic                     resp_val;
  logic                     resp_rdy;
  logic                     a_mux_sel;
  logic                     b_mux_sel;
  logic                     result_en;
  logic                     result_reset;
  logic [c_shamt_nbits-1:0] shamt;
  logic [c_nbits-1:0]       b_out;

  modport master (
    input  req_val, resp_rdy, b_out,
    output req_rdy, resp_val, a_mux_sel, b_mux_sel, result_en, result_reset, shamt
  );

  modport slave (
    output req_val, resp_rdy, b_out,
    input  req_rdy, resp_val, a_mux_sel, b_mux_sel, result_en, result_reset, shamt
  );

endinterface

// File: rtl/lab1_imul_ctz.sv
// Trailing-zero counter; an all-zero input reports c_nbits.
module lab1_imul_ctz
  import lab1_imul_pkg::*;
#(
  parameter int unsigned c_nbits       = nbits,
  parameter int unsigned c_shamt_nbits = shamt_nbits
) (
  input  logic [c_nbits-1:0]     in_bits,
  output logic [c_shamt_nbits:0] count
);

  localparam int unsigned cnt_w = c_shamt_nbits + 1;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    count = cnt_w'(c_nbits);
    for (int i = int'(c_nbits) - 1; i >= 0; i--) begin
      if (in_bits[i]) count = cnt_w'(i);
    end
  end

endmodule

// File: rtl/lab1_imul_int_mul_alt_ctrl.sv
// Controller for the zero-skipping iterative multiplier: handshakes, datapath
// selects/enables, multi-bit shift amount and a per-operation cycle counter.
module lab1_imul_int_mul_alt_ctrl
  import lab1_imul_pkg::*;
#(
  parameter int unsigned c_nbits       = nbits,
  parameter int unsigned c_shamt_nbits = shamt_nbits,
  parameter int unsigned c_max_shamt   = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  lab1_imul_int_mul_alt_ctrl_if.master  mul,
  output logic [5:0]                    lat_cycles
);

  localparam int unsigned                 cnt_w     = c_shamt_nbits + 1;
  localparam logic [c_shamt_nbits:0]      max_shamt = cnt_w'(c_max_shamt);

  state_e                 state;
  logic [c_shamt_nbits:0] tz;
  logic [c_shamt_nbits:0] tz_sat;

  lab1_imul_ctz #(
    .c_nbits       (c_nbits),
    .c_shamt_nbits (c_shamt_nbits)
  ) u_ctz (
    .in_bits (mul.b_out),
    .count   (tz)
  );

  assign tz_sat = (tz > max_shamt) ? max_shamt : tz;

  // State and latency counter; the counter restarts on accept and saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul.req_val) begin
            state      <= CALC;
            lat_cycles <= '0;
          end
        end
        CALC: begin
          if (lat_cycles != 6'd63) lat_cycles <= lat_cycles + 6'd1;
          if (mul.b_out == '0) state <= DONE;
        end
        DONE: begin
          if (mul.resp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state and b_out; everything is held low during reset.
  always_comb begin
    mul.req_rdy      = 1'b0;
    mul.resp_val     = 1'b0;
    mul.a_mux_sel    = 1'b0;
    mul.b_mux_sel    = 1'b0;
    mul.result_en    = 1'b0;
    mul.result_reset = 1'b0;
    mul.shamt        = '0;
    if (reset) begin
      case (state)
        IDLE: begin
          mul.req_rdy = 1'b1;
          if (mul.req_val) begin
            mul.a_mux_sel    = 1'b1;
            mul.b_mux_sel    = 1'b1;
            mul.result_reset = 1'b1;
          end
        end
        CALC: begin
          if (mul.b_out == '0) begin
            mul.shamt = '0;
          end else if (mul.b_out[0]) begin
            mul.result_en = 1'b1;
            mul.shamt     = c_shamt_nbits'(1);
          end else begin
            mul.shamt = c_shamt_nbits'(tz_sat);
          end
        end
        DONE: mul.resp_val = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_imul_int_mul_alt_ctrl.sv
// Directed bench: two controllers (shift caps 31 and 4) each driving a small datapath model.
module tb_lab1_imul_int_mul_alt_ctrl;
  import lab1_imul_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lab1_imul_int_mul_alt_ctrl_if bus0 ();
  lab1_imul_int_mul_alt_ctrl_if bus4 ();
  logic [5:0] lat0, lat4;

  lab1_imul_int_mul_alt_ctrl dut0 (
    .clk (clk), .reset (reset), .mul (bus0.master), .lat_cycles (lat0)
  );

  lab1_imul_int_mul_alt_ctrl #(.c_max_shamt(4)) dut4 (
    .clk (clk), .reset (reset), .mul (bus4.master), .lat_cycles (lat4)
  );

  // Stimulus and observation arrays, index 0 = dut0, 1 = dut4
  logic        req_val  [2];
  logic        resp_rdy [2];
  logic [31:0] a_in     [2];
  logic [31:0] b_in     [2];
  logic [31:0] a_reg    [2];
  logic [31:0] b_reg    [2];
  logic [31:0] res      [2];

  logic        o_req_rdy [2];
  logic        o_resp_val[2];
  logic        o_amux    [2];
  logic        o_bmux    [2];
  logic        o_en      [2];
  logic        o_rr      [2];
  logic [4:0]  o_sh      [2];
  logic [5:0]  o_lat     [2];

  assign bus0.req_val  = req_val[0];
  assign bus0.resp_rdy = resp_rdy[0];
  assign bus0.b_out    = b_reg[0];
  assign bus4.req_val  = req_val[1];
  assign bus4.resp_rdy = resp_rdy[1];
  assign bus4.b_out    = b_reg[1];

  assign o_req_rdy[0]  = bus0.req_rdy;      assign o_req_rdy[1]  = bus4.req_rdy;
  assign o_resp_val[0] = bus0.resp_val;     assign o_resp_val[1] = bus4.resp_val;
  assign o_amux[0]     = bus0.a_mux_sel;    assign o_amux[1]     = bus4.a_mux_sel;
  assign o_bmux[0]     = bus0.b_mux_sel;    assign o_bmux[1]     = bus4.b_mux_sel;
  assign o_en[0]       = bus0.result_en;    assign o_en[1]       = bus4.result_en;
  assign o_rr[0]       = bus0.result_reset; assign o_rr[1]       = bus4.result_reset;
  assign o_sh[0]       = bus0.shamt;        assign o_sh[1]       = bus4.shamt;
  assign o_lat[0]      = lat0;              assign o_lat[1]      = lat4;

  // Datapath model: a/b shift registers and accumulator
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      a_reg[d] <= o_amux[d] ? a_in[d] : (a_reg[d] << o_sh[d]);
      b_reg[d] <= o_bmux[d] ? b_in[d] : (b_reg[d] >> o_sh[d]);
      if (o_rr[d])      res[d] <= '0;
      else if (o_en[d]) res[d] <= res[d] + a_reg[d];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  logic       tr_en [64];
  logic [4:0] tr_sh [64];
  int         tr_n;
  int         k;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One complete op with resp_rdy held high; records the CALC (en, shamt) trace.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    @(negedge clk);
    a_in[d] = a; b_in[d] = b; req_val[d] = 1'b1; resp_rdy[d] = 1'b1;
    #1;
    check("accept_rdy",   64'(o_req_rdy[d]), 64'(1));
    check("accept_clear", 64'({o_amux[d], o_bmux[d], o_rr[d]}), 64'(3'b111));
    @(negedge clk);
    req_val[d] = 1'b0;
    #1;
    tr_n = 0;
    k    = 1;
    while (!o_resp_val[d] && k < 100) begin
      tr_en[tr_n] = o_en[d];
      tr_sh[tr_n] = o_sh[d];
      tr_n++;
      @(negedge clk); #1;
      k++;
    end
    check("resp_latency", 64'(k),          64'(exp_lat + 1));
    check("result",       64'(res[d]),     64'(exp_res));
    check("lat_cycles",   64'(o_lat[d]),   64'(exp_lat));
    check("done_rdy",     64'(o_req_rdy[d]), 64'(0));
    @(negedge clk); #1;
    check("back_idle", 64'({o_req_rdy[d], o_resp_val[d]}), 64'(2'b10));
  endtask

  initial begin
    logic seen;
    for (int d = 0; d < 2; d++) begin
      req_val[d] = 1'b0; resp_rdy[d] = 1'b0;
      a_in[d] = '0; b_in[d] = '0; a_reg[d] = '0; b_reg[d] = '0; res[d] = '0;
    end

    // Reset: outputs forced low, then idle-ready on release
    repeat (2) @(negedge clk);
    #1;
    check("rst_rdy0", 64'(o_req_rdy[0]),  64'(0));
    check("rst_rdy4", 64'(o_req_rdy[1]),  64'(0));
    check("rst_val0", 64'(o_resp_val[0]), 64'(0));
    reset = 1'b1;
    #1;
    check("rel_rdy0", 64'(o_req_rdy[0]),  64'(1));
    check("rel_rdy4", 64'(o_req_rdy[1]),  64'(1));
    check("rel_val0", 64'(o_resp_val[0]), 64'(0));
    check("rel_lat0", 64'(o_lat[0]),      64'(0));
    check("rel_sel0", 64'({o_amux[0], o_rr[0], o_en[0], o_sh[0]}), 64'(0));

    // 3 * 5: (1,1) (0,1) (1,1) (0,0)
    run_op(0, 32'd3, 32'd5, 32'd15, 4);
    check("t35_n", 64'(tr_n), 64'(4));
    check("t35_0", 64'({tr_en[0], tr_sh[0]}), 64'(6'b1_00001));
    check("t35_1", 64'({tr_en[1], tr_sh[1]}), 64'(6'b0_00001));
    check("t35_2", 64'({tr_en[2], tr_sh[2]}), 64'(6'b1_00001));
    check("t35_3", 64'({tr_en[3], tr_sh[3]}), 64'(6'b0_00000));

    // b = 0: single zero-check cycle
    run_op(0, 32'd7, 32'd0, 32'd0, 1);
    check("tb0_0", 64'({tr_en[0], tr_sh[0]}), 64'(6'b0_00000));

    // b = 0x80000000, cap 31: one 31-bit skip
    run_op(0, 32'd1, 32'h8000_0000, 32'h8000_0000, 3);
    check("tmsb_0", 64'({tr_en[0], tr_sh[0]}), 64'(6'b0_11111));
    check("tmsb_1", 64'({tr_en[1], tr_sh[1]}), 64'(6'b1_00001));
    check("tmsb_2", 64'({tr_en[2], tr_sh[2]}), 64'(6'b0_00000));

    // Same operand, cap 4: 7x4 + 3 then add, zero
    run_op(1, 32'd1, 32'h8000_0000, 32'h8000_0000, 10);
    for (int i = 0; i < 7; i++) check("tcap_4", 64'({tr_en[i], tr_sh[i]}), 64'(6'b0_00100));
    check("tcap_3",   64'({tr_en[7], tr_sh[7]}), 64'(6'b0_00011));
    check("tcap_add", 64'({tr_en[8], tr_sh[8]}), 64'(6'b1_00001));
    check("tcap_z",   64'({tr_en[9], tr_sh[9]}), 64'(6'b0_00000));

    // All ones: 32 add cycles then zero check
    run_op(0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    check("tones_0",  64'({tr_en[0],  tr_sh[0]}),  64'(6'b1_00001));
    check("tones_31", 64'({tr_en[31], tr_sh[31]}), 64'(6'b1_00001));
    check("tones_32", 64'({tr_en[32], tr_sh[32]}), 64'(6'b0_00000));

    // 0x12345 * 0x30: skip 4, then two adds
    run_op(0, 32'h0001_2345, 32'h0000_0030, 32'h0036_9CF0, 4);
    check("t30_0", 64'({tr_en[0], tr_sh[0]}), 64'(6'b0_00100));

    // Response back-pressure with req_val held high
    @(negedge clk);
    a_in[0] = 32'd2; b_in[0] = 32'd3; req_val[0] = 1'b1; resp_rdy[0] = 1'b0;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!o_resp_val[0] && k < 100);
    check("hold_latency", 64'(k), 64'(4));
    for (int i = 0; i < 3; i++) begin
      check("hold_val",  64'(o_resp_val[0]), 64'(1));
      check("hold_rdy",  64'(o_req_rdy[0]),  64'(0));
      check("hold_res",  64'(res[0]),        64'(6));
      check("hold_sel",  64'({o_amux[0], o_rr[0]}), 64'(0));
      if (i < 2) begin
        @(negedge clk); #1;
      end
    end
    resp_rdy[0] = 1'b1; a_in[0] = 32'd5; b_in[0] = 32'd1;
    #1;
    check("hold_nocomb", 64'({o_resp_val[0], o_req_rdy[0]}), 64'(2'b10));
    @(negedge clk); #1;
    check("b2b_idle",   64'({o_req_rdy[0], o_resp_val[0]}), 64'(2'b10));
    check("b2b_accept", 64'({o_amux[0], o_bmux[0], o_rr[0]}), 64'(3'b111));
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!o_resp_val[0] && k < 100);
    req_val[0] = 1'b0;
    check("b2b_latency", 64'(k),        64'(3));
    check("b2b_res",     64'(res[0]),   64'(5));
    check("b2b_lat",     64'(o_lat[0]), 64'(2));
    @(negedge clk); #1;

    // Reset mid-CALC: no response, clean restart
    @(negedge clk);
    a_in[0] = 32'd3; b_in[0] = 32'd5; req_val[0] = 1'b1; resp_rdy[0] = 1'b1;
    @(negedge clk); req_val[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_out", 64'({o_req_rdy[0], o_en[0], o_sh[0], o_resp_val[0]}), 64'(0));
    check("mid_rst_lat", 64'(o_lat[0]), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (o_resp_val[0]) seen = 1'b1;
    end
    check("mid_rst_noresp", 64'(seen), 64'(0));
    check("mid_rst_rdy",    64'(o_req_rdy[0]), 64'(1));
    run_op(0, 32'd3, 32'd5, 32'd15, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
